// File: rtl/axil_ctrl_regfile.sv
// AXI4-Lite control/status register file with per-slot RW / RO / write-pulse access.
// Define AXIL_CTRL_ERR_RESP_EN to return SLVERR on illegal accesses (default: always OKAY).
module axil_ctrl_regfile #(
    parameter int                                 N_REGS         = 16,
    parameter int                                 AXIL_DATA_BITS = 64,
    parameter int                                 DATA_BITS      = AXIL_DATA_BITS,
    parameter int                                 ADDR_BITS      = 12,
    parameter logic [N_REGS-1:0]                  RW_MASK        = 16'h0100,
    parameter logic [N_REGS-1:0]                  PULSE_MASK     = 16'h0001,
    parameter logic [N_REGS-1:0][DATA_BITS-1:0]   RESET_VAL      = '0
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,

    input  logic [ADDR_BITS-1:0]                  axi_ctrl_awaddr,
    input  logic                                  axi_ctrl_awvalid,
    output logic                                  axi_ctrl_awready,
    input  logic [DATA_BITS-1:0]                  axi_ctrl_wdata,
    input  logic [DATA_BITS/8-1:0]                axi_ctrl_wstrb,
    input  logic                                  axi_ctrl_wvalid,
    output logic                                  axi_ctrl_wready,
    output logic [1:0]                            axi_ctrl_bresp,
    output logic                                  axi_ctrl_bvalid,
    input  logic                                  axi_ctrl_bready,
    input  logic [ADDR_BITS-1:0]                  axi_ctrl_araddr,
    input  logic                                  axi_ctrl_arvalid,
    output logic                                  axi_ctrl_arready,
    output logic [DATA_BITS-1:0]                  axi_ctrl_rdata,
    output logic [1:0]                            axi_ctrl_rresp,
    output logic                                  axi_ctrl_rvalid,
    input  logic                                  axi_ctrl_rready,

    input  logic [N_REGS-1:0][DATA_BITS-1:0]      reg_i,
    output logic [N_REGS-1:0][DATA_BITS-1:0]      reg_o,
    output logic [N_REGS-1:0]                     wr_pulse
);

    localparam int                IDX_BITS  = $clog2(N_REGS);
    localparam int                STRB_BITS = DATA_BITS / 8;
    localparam int                ADDR_LSB  = $clog2(STRB_BITS);
    localparam logic [N_REGS-1:0] STORED    = RW_MASK | PULSE_MASK;
    localparam logic [N_REGS-1:0] RW_ONLY   = RW_MASK & ~PULSE_MASK;
    localparam logic [1:0]        RESP_OKAY = 2'b00;
`ifdef AXIL_CTRL_ERR_RESP_EN
    localparam logic [1:0]        RESP_ERR  = 2'b10;
`else
    localparam logic [1:0]        RESP_ERR  = 2'b00;
`endif

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA}                 rstate_e;

    // Range check uses the whole address so out-of-range indices don't alias onto low slots.
    function automatic logic in_range(input logic [ADDR_BITS-1:0] addr);
        logic [ADDR_BITS-1:0] slot;
        slot = addr >> ADDR_LSB;
        return slot < ADDR_BITS'(N_REGS);
    endfunction

    wstate_e                           wstate_q, wstate_d;
    rstate_e                           rstate_q, rstate_d;
    logic                              awready_q, awready_d;
    logic                              wready_q, wready_d;
    logic                              bvalid_q, bvalid_d;
    logic [1:0]                        bresp_q, bresp_d;
    logic                              arready_q, arready_d;
    logic                              rvalid_q, rvalid_d;
    logic [1:0]                        rresp_q, rresp_d;
    logic [DATA_BITS-1:0]              rdata_q, rdata_d;
    logic [ADDR_BITS-1:0]              awaddr_q, awaddr_d;
    logic [DATA_BITS-1:0]              wdata_q, wdata_d;
    logic [STRB_BITS-1:0]              wstrb_q, wstrb_d;
    logic [N_REGS-1:0][DATA_BITS-1:0]  store_q, store_d;
    logic [N_REGS-1:0]                 wr_pulse_q, wr_pulse_d;

    logic                  aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
    logic [ADDR_BITS-1:0]  cmt_addr;
    logic [DATA_BITS-1:0]  cmt_data;
    logic [STRB_BITS-1:0]  cmt_strb;
    logic [IDX_BITS-1:0]   cmt_idx, rd_idx;

    assign aw_hs = awready_q & axi_ctrl_awvalid;
    assign w_hs  = wready_q  & axi_ctrl_wvalid;
    assign ar_hs = arready_q & axi_ctrl_arvalid;

    // The final handshake may deliver either half live from the bus; the other half comes from capture.
    assign cmt_addr = (wstate_q == W_ADDR) ? awaddr_q : axi_ctrl_awaddr;
    assign cmt_data = (wstate_q == W_DATA) ? wdata_q  : axi_ctrl_wdata;
    assign cmt_strb = (wstate_q == W_DATA) ? wstrb_q  : axi_ctrl_wstrb;
    assign cmt_idx  = cmt_addr[ADDR_LSB +: IDX_BITS];
    assign wr_ok    = in_range(cmt_addr) && STORED[cmt_idx];
    assign rd_idx   = axi_ctrl_araddr[ADDR_LSB +: IDX_BITS];
    assign rd_ok    = in_range(axi_ctrl_araddr);

    always_comb begin
        wstate_d   = wstate_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        commit     = 1'b0;
        wr_pulse_d = '0;

        case (wstate_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wstate_d = W_RESP;
                    commit   = 1'b1;
                end else if (aw_hs) begin
                    wstate_d = W_ADDR;
                    awaddr_d = axi_ctrl_awaddr;
                end else if (w_hs) begin
                    wstate_d = W_DATA;
                    wdata_d  = axi_ctrl_wdata;
                    wstrb_d  = axi_ctrl_wstrb;
                end
            end
            W_ADDR: if (w_hs) begin
                wstate_d = W_RESP;
                commit   = 1'b1;
            end
            W_DATA: if (aw_hs) begin
                wstate_d = W_RESP;
                commit   = 1'b1;
            end
            W_RESP: if (bvalid_q && axi_ctrl_bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase

        // Pulse slots self-clear every cycle, so a write merges onto zero.
        for (int unsigned i = 0; i < N_REGS; i++)
            store_d[i] = PULSE_MASK[i] ? '0 : store_q[i];

        if (commit) begin
            bresp_d = wr_ok ? RESP_OKAY : RESP_ERR;
            if (wr_ok) begin
                wr_pulse_d[cmt_idx] = 1'b1;
                for (int unsigned b = 0; b < STRB_BITS; b++)
                    if (cmt_strb[b]) store_d[cmt_idx][b*8 +: 8] = cmt_data[b*8 +: 8];
            end
        end

        awready_d = (wstate_d == W_IDLE) || (wstate_d == W_DATA);
        wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_ADDR);
        bvalid_d  = (wstate_d == W_RESP);
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        case (rstate_q)
            R_IDLE: if (ar_hs) begin
                rstate_d = R_DATA;
                if (!rd_ok) begin
                    rdata_d = '0;
                    rresp_d = RESP_ERR;
                end else begin
                    rresp_d = RESP_OKAY;
                    if (!STORED[rd_idx])         rdata_d = reg_i[rd_idx];
                    else if (PULSE_MASK[rd_idx]) rdata_d = '0;
                    else                         rdata_d = store_q[rd_idx];
                end
            end
            R_DATA: if (rvalid_q && axi_ctrl_rready) begin
                rstate_d = R_IDLE;
                rdata_d  = '0;
                rresp_d  = RESP_OKAY;
            end
            default: rstate_d = R_IDLE;
        endcase

        arready_d = (rstate_d == R_IDLE);
        rvalid_d  = (rstate_d == R_DATA);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wstate_q   <= W_IDLE;
            rstate_q   <= R_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= '0;
            rdata_q    <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wr_pulse_q <= '0;
            for (int unsigned i = 0; i < N_REGS; i++)
                store_q[i] <= RW_ONLY[i] ? RESET_VAL[i] : '0;
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wr_pulse_q <= wr_pulse_d;
            store_q    <= store_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_REGS; i++)
            reg_o[i] = STORED[i] ? store_q[i] : '0;
    end

    assign axi_ctrl_awready = awready_q;
    assign axi_ctrl_wready  = wready_q;
    assign axi_ctrl_bvalid  = bvalid_q;
    assign axi_ctrl_bresp   = bresp_q;
    assign axi_ctrl_arready = arready_q;
    assign axi_ctrl_rvalid  = rvalid_q;
    assign axi_ctrl_rresp   = rresp_q;
    assign axi_ctrl_rdata   = rdata_q;
    assign wr_pulse         = wr_pulse_q;

endmodule

// File: tb/tb_axil_ctrl_regfile.sv
// Scoreboard bench for axil_ctrl_regfile: B/R expectations queued at issue, checked at the beat.
module tb_axil_ctrl_regfile;

    localparam int         N  = 16;
    localparam int         DW = 64;
    localparam int         AW = 12;
    localparam logic [1:0] OKAY = 2'b00;
`ifdef AXIL_CTRL_ERR_RESP_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [AW-1:0]     awaddr, araddr;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [DW-1:0]     wdata, rdata;
    logic [DW/8-1:0]   wstrb;
    logic [1:0]        bresp, rresp;
    logic [N-1:0][DW-1:0] reg_i, reg_o;
    logic [N-1:0]      wr_pulse;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rexp_t;

    logic [1:0] bq[$];
    rexp_t      rq[$];
    rexp_t      re;
    int         checks = 0;
    int         errors = 0;

    axil_ctrl_regfile dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .axi_ctrl_awaddr  (awaddr),
        .axi_ctrl_awvalid (awvalid),
        .axi_ctrl_awready (awready),
        .axi_ctrl_wdata   (wdata),
        .axi_ctrl_wstrb   (wstrb),
        .axi_ctrl_wvalid  (wvalid),
        .axi_ctrl_wready  (wready),
        .axi_ctrl_bresp   (bresp),
        .axi_ctrl_bvalid  (bvalid),
        .axi_ctrl_bready  (bready),
        .axi_ctrl_araddr  (araddr),
        .axi_ctrl_arvalid (arvalid),
        .axi_ctrl_arready (arready),
        .axi_ctrl_rdata   (rdata),
        .axi_ctrl_rresp   (rresp),
        .axi_ctrl_rvalid  (rvalid),
        .axi_ctrl_rready  (rready),
        .reg_i            (reg_i),
        .reg_o            (reg_o),
        .wr_pulse         (wr_pulse)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshakes complete at the next posedge iff valid&ready seen at the negedge.
    initial forever begin
        @(negedge aclk);
        if (aresetn && bvalid && bready) begin
            if (bq.size() == 0) check("b_unexpected", 1, 0);
            else                check("bresp", bresp, bq.pop_front());
        end
        if (aresetn && rvalid && rready) begin
            if (rq.size() == 0) check("r_unexpected", 1, 0);
            else begin
                re = rq.pop_front();
                check("rdata", rdata, re.data);
                check("rresp", rresp, re.resp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send_aw(input logic [AW-1:0] a);
        int t = 0;
        bit rdy;
        awaddr  = a;
        awvalid = 1'b1;
        do begin
            rdy = awready;
            cyc(1);
            t++;
        end while (!rdy && t < 50);
        awvalid = 1'b0;
        check("aw_hs", rdy, 1);
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        int t = 0;
        bit rdy;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        do begin
            rdy = wready;
            cyc(1);
            t++;
        end while (!rdy && t < 50);
        wvalid = 1'b0;
        check("w_hs", rdy, 1);
    endtask

    task automatic wr_same(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] s, input logic [1:0] exp_resp);
        int t = 0;
        bit rdy;
        bq.push_back(exp_resp);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        do begin
            rdy = awready && wready;
            cyc(1);
            t++;
        end while (!rdy && t < 50);
        awvalid = 1'b0; wvalid = 1'b0;
        check("aww_hs", rdy, 1);
        check("b_latency", bvalid, 1);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp_d, input logic [1:0] exp_r);
        int t = 0;
        bit rdy;
        rq.push_back('{data: exp_d, resp: exp_r});
        araddr  = a;
        arvalid = 1'b1;
        do begin
            rdy = arready;
            cyc(1);
            t++;
        end while (!rdy && t < 50);
        arvalid = 1'b0;
        check("ar_hs", rdy, 1);
        check("r_latency", rvalid, 1);
    endtask

    initial begin
        int t;
        bit rdy;
        aresetn = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1;
        reg_i = '0;
        reg_i[3] = 64'hABCD;
        cyc(3);
        check("rst_hs_outs", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        check("rst_rdata", rdata, 0);
        check("rst_resp", {bresp, rresp}, 4'b0);
        check("rst_reg8", reg_o[8], 0);
        check("rst_pulse", wr_pulse, 0);
        aresetn = 1'b1;
        cyc(1);
        check("idle_ready", {awready, wready, arready}, 3'b111);

        // Same-cycle AW+W, then read back.
        wr_same(12'h040, 64'hDEADBEEF, 8'hFF, OKAY);
        check("t1_reg8", reg_o[8], 64'hDEADBEEF);
        check("t1_pulse", wr_pulse, 16'h0100);
        cyc(1);
        check("t1_pulse_off", wr_pulse, 0);
        rd(12'h040, 64'hDEADBEEF, OKAY);
        cyc(2);

        // W three cycles ahead of AW, then AW two cycles ahead of W.
        bq.push_back(OKAY);
        send_w(64'h1234, 8'hFF);
        cyc(2);
        send_aw(12'h040);
        check("t2a_reg8", reg_o[8], 64'h1234);
        check("t2a_pulse", wr_pulse, 16'h0100);
        bq.push_back(OKAY);
        send_aw(12'h040);
        cyc(1);
        send_w(64'h5678, 8'hFF);
        check("t2b_reg8", reg_o[8], 64'h5678);
        check("t2b_pulse", wr_pulse, 16'h0100);
        cyc(2);

        // Pulse slot.
        wr_same(12'h000, 64'h1, 8'hFF, OKAY);
        check("t3_reg0", reg_o[0], 1);
        check("t3_pulse", wr_pulse, 16'h0001);
        cyc(1);
        check("t3_reg0_clr", reg_o[0], 0);
        rd(12'h000, 64'h0, OKAY);
        cyc(2);

        // RO slot write and out-of-range read.
        wr_same(12'h018, 64'hFFFF, 8'hFF, ERR);
        check("t4_reg3", reg_o[3], 0);
        check("t4_pulse", wr_pulse, 0);
        check("t4_reg8", reg_o[8], 64'h5678);
        cyc(1);
        rd(12'h018, 64'hABCD, OKAY);
        cyc(2);
        rd(12'h100, 64'h0, ERR);
        cyc(2);

        // Partial and empty strobes.
        wr_same(12'h040, 64'hFFFFFFFF, 8'hFF, OKAY);
        cyc(1);
        wr_same(12'h040, 64'h0, 8'h03, OKAY);
        check("t5_reg8", reg_o[8], 64'hFFFF0000);
        cyc(1);
        wr_same(12'h040, 64'h1111, 8'h00, OKAY);
        check("strb0_reg8", reg_o[8], 64'hFFFF0000);
        check("strb0_pulse", wr_pulse, 16'h0100);
        cyc(1);

        // Read handshake on the write-commit edge returns the old value.
        bq.push_back(OKAY);
        rq.push_back('{data: 64'hFFFF0000, resp: OKAY});
        awaddr = 12'h040; wdata = 64'h77; wstrb = 8'hFF; araddr = 12'h040;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        t = 0;
        do begin
            rdy = awready && wready && arready;
            cyc(1);
            t++;
        end while (!rdy && t < 50);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("coll_hs", rdy, 1);
        check("coll_reg8", reg_o[8], 64'h77);
        cyc(2);
        rd(12'h040, 64'h77, OKAY);
        cyc(2);

        // B backpressure blocks a second AW.
        bready = 1'b0;
        wr_same(12'h040, 64'h99, 8'hFF, OKAY);
        awaddr = 12'h040; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", bvalid, 1);
            check("bp_ready", {awready, wready}, 2'b00);
            cyc(1);
        end
        awvalid = 1'b0;
        bready  = 1'b1;
        cyc(2);
        check("bp_reg8", reg_o[8], 64'h99);

        // Reset in W_ADDR drops the write with no B beat.
        send_aw(12'h040);
        aresetn = 1'b0;
        cyc(2);
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_reg8", reg_o[8], 0);
        check("mid_rst_ready", {awready, wready}, 2'b00);
        aresetn = 1'b1;
        cyc(4);
        check("post_rst_bvalid", bvalid, 0);
        check("post_rst_ready", {awready, wready}, 2'b11);

        cyc(3);
        check("bq_left", bq.size(), 0);
        check("rq_left", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
